// File: rtl/fft_frame_src.sv
// fft_frame_src: captures one frame of ADC samples per start pulse and streams
// them to an FFT core over AXI-Stream as {16'h0 imaginary, 16-bit real}.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_start            one-cycle pulse arming capture of one frame (IDLE only)
//   i_ad_data          ADC sample code, DATA_W bits
//   i_ad_valid         sample strobe
//   o_m_axis_tdata     [15:0] real part, [31:16] imaginary part (always 0)
//   o_m_axis_tvalid    AXI-Stream valid
//   i_m_axis_tready    AXI-Stream ready
//   o_m_axis_tlast     marks the FRAME_LEN-th beat
//   o_busy             high while capturing or draining
//   o_frame_done       one-cycle pulse after the last beat
//   o_overflow         sticky: a sample of this frame was dropped
module fft_frame_src #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FRAME_LEN  = 4096,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          OFFSET_BIN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_ad_data,
    input  logic              i_ad_valid,
    output logic [31:0]       o_m_axis_tdata,
    output logic              o_m_axis_tvalid,
    input  logic              i_m_axis_tready,
    output logic              o_m_axis_tlast,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overflow
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN) + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_overflow;

    logic              w_active;
    logic              w_empty;
    logic              w_full;
    logic              w_tvalid;
    logic              w_tlast;
    logic              w_rd;
    logic              w_room;
    logic              w_wr;
    logic              w_drop;
    logic              w_arm;
    logic [DATA_W-1:0] w_code;
    logic [15:0]       w_real;

    // Sample conversion: offset-binary becomes two's complement by flipping the MSB.
    always_comb begin
        w_code = i_ad_data;
        if (OFFSET_BIN) begin
            w_code[DATA_W-1] = ~i_ad_data[DATA_W-1];
            w_real           = 16'($signed(w_code));
        end else begin
            w_real = 16'(w_code);
        end
    end

    always_comb begin
        w_active = (r_state == CAPTURE) || (r_state == DRAIN);
        w_empty  = (r_count == '0);
        w_full   = (r_count == FULL_CNT);
        w_tvalid = w_active && !w_empty;
        w_tlast  = w_tvalid && (r_out_cnt == LAST_CNT);
        w_rd     = w_tvalid && i_m_axis_tready;
        // Once the frame is fully captured, further strobes are not part of it.
        w_room   = (r_in_cnt != FRAME_CNT);
        // A simultaneous read frees the slot, so a full FIFO still accepts.
        w_wr     = (r_state == CAPTURE) && i_ad_valid && w_room && (!w_full || w_rd);
        w_drop   = (r_state == CAPTURE) && i_ad_valid && w_room && w_full && !w_rd;
        w_arm    = (r_state == IDLE) && i_start;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                // The last beat can already go out in the cycle capture completes.
                if (r_in_cnt == FRAME_CNT) begin
                    w_state_next = (w_rd && w_tlast) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (w_rd && w_tlast) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (w_arm) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by r_count and outputs are gated.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_real;
        end
    end

    always_comb begin
        o_m_axis_tvalid = w_tvalid;
        o_m_axis_tdata  = w_tvalid ? {16'h0000, r_mem[r_rd_ptr]} : 32'h0;
        o_m_axis_tlast  = w_tlast;
        o_busy          = w_active;
        o_frame_done    = (r_state == DONE);
        o_overflow      = r_overflow;
    end

endmodule

// File: tb/tb_fft_frame_src.sv
// Bench for fft_frame_src: three instances (FRAME_LEN 16 / 32 with offset-binary,
// FRAME_LEN 8 straight binary) share data/valid/ready and have separate starts.
module tb_fft_frame_src;

    logic        clk;
    logic        rst_n;
    logic        start [3];
    logic [11:0] ad_data;
    logic        ad_valid;
    logic        tready;
    logic [31:0] tdata [3];
    logic        tvalid [3];
    logic        tlast [3];
    logic        busy [3];
    logic        done [3];
    logic        ovf [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fft_frame_src #(.DATA_W(12), .FRAME_LEN(16), .FIFO_DEPTH(16), .OFFSET_BIN(1'b1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_ad_data(ad_data),
        .i_ad_valid(ad_valid), .o_m_axis_tdata(tdata[0]), .o_m_axis_tvalid(tvalid[0]),
        .i_m_axis_tready(tready), .o_m_axis_tlast(tlast[0]), .o_busy(busy[0]),
        .o_frame_done(done[0]), .o_overflow(ovf[0])
    );
    fft_frame_src #(.DATA_W(12), .FRAME_LEN(32), .FIFO_DEPTH(16), .OFFSET_BIN(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_ad_data(ad_data),
        .i_ad_valid(ad_valid), .o_m_axis_tdata(tdata[1]), .o_m_axis_tvalid(tvalid[1]),
        .i_m_axis_tready(tready), .o_m_axis_tlast(tlast[1]), .o_busy(busy[1]),
        .o_frame_done(done[1]), .o_overflow(ovf[1])
    );
    fft_frame_src #(.DATA_W(12), .FRAME_LEN(8), .FIFO_DEPTH(16), .OFFSET_BIN(1'b0)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_ad_data(ad_data),
        .i_ad_valid(ad_valid), .o_m_axis_tdata(tdata[2]), .o_m_axis_tvalid(tvalid[2]),
        .i_m_axis_tready(tready), .o_m_axis_tlast(tlast[2]), .o_busy(busy[2]),
        .o_frame_done(done[2]), .o_overflow(ovf[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fl(int i);
        case (i)
            0:       return 16;
            1:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic bit ob(int i);
        return (i != 2);
    endfunction

    // Offset-binary code c means the signed value c - 2^(DATA_W-1).
    function automatic logic [15:0] conv(int i, logic [11:0] c);
        if (ob(i)) return 16'(int'(c) - 2048);
        return {4'h0, c};
    endfunction

    // ---------------- Behavioural model ----------------
    // Per instance: phase (0 idle, 1 capture, 2 drain, 3 done), the list of accepted
    // samples acc[0..na-1], how many have been sent (nb), and the sticky drop flag.
    int          ph [3];
    int          na [3];
    int          nb [3];
    logic        mov [3];
    logic [15:0] acc [3][64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ph[i]  <= 0;
                na[i]  <= 0;
                nb[i]  <= 0;
                mov[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit   ev;
                bit   hs;
                bit   lh;
                int   n_ph;
                int   n_na;
                int   n_nb;
                logic n_mov;
                ev    = (ph[i] == 1 || ph[i] == 2) && (na[i] > nb[i]);
                hs    = ev && tready;
                lh    = hs && (nb[i] == fl(i) - 1);
                n_ph  = ph[i];
                n_na  = na[i];
                n_nb  = nb[i] + (hs ? 1 : 0);
                n_mov = mov[i];
                case (ph[i])
                    0: if (start[i]) begin
                        n_ph  = 1;
                        n_na  = 0;
                        n_nb  = 0;
                        n_mov = 1'b0;
                    end
                    1: begin
                        if (ad_valid && na[i] < fl(i)) begin
                            if ((na[i] - nb[i]) < 16 || hs) begin
                                acc[i][na[i]] <= conv(i, ad_data);
                                n_na = na[i] + 1;
                            end else begin
                                n_mov = 1'b1;
                            end
                        end
                        if (na[i] == fl(i)) n_ph = lh ? 3 : 2;
                    end
                    2: if (lh) n_ph = 3;
                    default: n_ph = 0;
                endcase
                ph[i]  <= n_ph;
                na[i]  <= n_na;
                nb[i]  <= n_nb;
                mov[i] <= n_mov;
            end
        end
    end

    // ---------------- Handshake log ----------------
    int          beats [3] = '{0, 0, 0};
    logic [31:0] dat [3][256];
    logic        lf [3][256];
    int          last_cyc [3] = '{0, 0, 0};
    int          done_cyc [3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (tvalid[i] && tready) begin
                    dat[i][beats[i] & 255] <= tdata[i];
                    lf[i][beats[i] & 255]  <= tlast[i];
                    beats[i]               <= beats[i] + 1;
                    if (tlast[i]) last_cyc[i] <= cyc;
                end
                if (done[i]) done_cyc[i] <= cyc;
            end
        end
    end

    // ---------------- Checking ----------------
    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h cycle=%0d", name, idx, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            bit          ev;
            logic [31:0] ed;
            ev = (ph[i] == 1 || ph[i] == 2) && (na[i] > nb[i]);
            ed = ev ? {16'h0000, acc[i][nb[i]]} : 32'h0;
            chk("tvalid", i, 32'(tvalid[i]), 32'(ev));
            chk("tdata", i, tdata[i], ed);
            chk("tlast", i, 32'(tlast[i]), 32'(ev && (nb[i] == fl(i) - 1)));
            chk("busy", i, 32'(busy[i]), 32'(ph[i] == 1 || ph[i] == 2));
            chk("frame_done", i, 32'(done[i]), 32'(ph[i] == 3));
            chk("overflow", i, 32'(ovf[i]), 32'(mov[i]));
        end
    endtask

    task automatic chk_zero(string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_tvalid"}, i, 32'(tvalid[i]), 32'h0);
            chk({tag, "_tlast"}, i, 32'(tlast[i]), 32'h0);
            chk({tag, "_tdata"}, i, tdata[i], 32'h0);
            chk({tag, "_busy"}, i, 32'(busy[i]), 32'h0);
            chk({tag, "_done"}, i, 32'(done[i]), 32'h0);
            chk({tag, "_ovf"}, i, 32'(ovf[i]), 32'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int budget);
        int n;
        n = 0;
        while (!done[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done[i]) begin
            errors++;
            $display("FAIL done_timeout[%0d] actual=no frame_done required=frame_done within %0d",
                     i, budget);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int sent;
        clk      = 1'b0;
        rst_n    = 1'b0;
        start    = '{1'b0, 1'b0, 1'b0};
        ad_data  = '0;
        ad_valid = 1'b0;
        tready   = 1'b1;
        #3;
        chk_zero("reset");
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame: codes 0..15 on FRAME_LEN 16, ready always high.
        pulse_start(0);
        base = beats[0];
        for (int k = 0; k < 16; k++) begin
            ad_valid = 1'b1;
            ad_data  = 12'(k);
            tick();
        end
        ad_valid = 1'b0;
        wait_done(0, 100);
        chk("t1_beats", 0, 32'(beats[0] - base), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk("t1_data", k, dat[0][(base + k) & 255], 32'h0000F800 + 32'(k));
            chk("t1_last", k, 32'(lf[0][(base + k) & 255]), 32'(k == 15));
        end
        chk("t1_done_latency", 0, 32'(done_cyc[0] - last_cyc[0]), 32'd1);
        chk("t1_overflow", 0, 32'(ovf[0]), 32'h0);

        // Back-pressure: 20 stall cycles on FRAME_LEN 32 force drops.
        pulse_start(1);
        base = beats[1];
        for (int k = 0; k < 24; k++) begin
            ad_valid = 1'b1;
            ad_data  = 12'(k);
            tready   = (k < 4);
            tick();
        end
        tready = 1'b1;
        wait_done(1, 200);
        ad_valid = 1'b0;
        chk("t2_overflow", 1, 32'(ovf[1]), 32'h1);
        chk("t2_beats", 1, 32'(beats[1] - base), 32'd32);
        chk("t2_first", 1, dat[1][base & 255], 32'h0000F800);
        for (int k = 0; k < 32; k++) begin
            chk("t2_last", k, 32'(lf[1][(base + k) & 255]), 32'(k == 31));
        end

        // Sparse input, toggling ready.
        pulse_start(0);
        base = beats[0];
        n    = 0;
        sent = 0;
        while (sent < 16) begin
            ad_valid = (n % 4 == 0);
            if (n % 4 == 0) begin
                ad_data = 12'(100 + sent);
                sent++;
            end
            tready = (n % 2 == 0);
            tick();
            n++;
        end
        ad_valid = 1'b0;
        tready   = 1'b1;
        wait_done(0, 200);
        chk("t3_beats", 0, 32'(beats[0] - base), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk("t3_data", k, dat[0][(base + k) & 255], 32'h0000F864 + 32'(k));
        end
        chk("t3_overflow", 0, 32'(ovf[0]), 32'h0);

        // Restart clears overflow; start while busy is ignored.
        pulse_start(1);
        chk("t4_ovf_cleared", 1, 32'(ovf[1]), 32'h0);
        chk("t4_busy", 1, 32'(busy[1]), 32'h1);
        base = beats[1];
        for (int k = 0; k < 32; k++) begin
            ad_valid = 1'b1;
            ad_data  = 12'(k);
            start[1] = (k == 5);
            tick();
        end
        start[1] = 1'b0;
        ad_valid = 1'b0;
        wait_done(1, 100);
        chk("t4_beats", 1, 32'(beats[1] - base), 32'd32);
        chk("t4_last", 1, 32'(lf[1][(base + 31) & 255]), 32'h1);
        chk("t4_busy_after", 1, 32'(busy[1]), 32'h0);

        // Reset in the middle of a frame, then a clean frame.
        pulse_start(0);
        base = beats[0];
        n    = 0;
        while ((beats[0] - base) < 7 && n < 50) begin
            ad_valid = 1'b1;
            ad_data  = 12'(n);
            tick();
            n++;
        end
        chk("t5_reached_beat7", 0, 32'(beats[0] - base), 32'd7);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        ad_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(0);
        base = beats[0];
        for (int k = 0; k < 16; k++) begin
            ad_valid = 1'b1;
            ad_data  = 12'(k);
            tick();
        end
        ad_valid = 1'b0;
        wait_done(0, 100);
        chk("t5_beats", 0, 32'(beats[0] - base), 32'd16);
        chk("t5_first", 0, dat[0][base & 255], 32'h0000F800);
        chk("t5_last", 0, dat[0][(base + 15) & 255], 32'h0000F80F);

        // Straight binary pass-through.
        pulse_start(2);
        base = beats[2];
        for (int k = 0; k < 8; k++) begin
            ad_valid = 1'b1;
            ad_data  = (k == 0) ? 12'hFFF : 12'(k);
            tick();
        end
        ad_valid = 1'b0;
        wait_done(2, 100);
        chk("t6_beats", 2, 32'(beats[2] - base), 32'd8);
        chk("t6_fff", 2, dat[2][base & 255], 32'h00000FFF);
        chk("t6_one", 2, dat[2][(base + 1) & 255], 32'h00000001);
        chk("t6_tlast", 2, 32'(lf[2][(base + 7) & 255]), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_src.md
FFT_FRAME_SRC -- requirements
Module: fft_frame_src

Interface
REQ-001 Parameter DATA_W, default 12: ADC sample width, legal range 8..16.
REQ-002 Parameter FRAME_LEN, default 4096: samples per FFT frame, a power of two, 8..65536.
REQ-003 Parameter FIFO_DEPTH, default 16: sample buffer depth, a power of two, at least 4.
REQ-004 Parameter OFFSET_BIN, default 1: 1 = ADC code is offset-binary and its MSB is inverted to form two's complement; 0 = pass through.
REQ-005 clk  in  1  single system clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle pulse that arms capture of one frame.
REQ-008 ad_data  in  DATA_W  ADC sample.
REQ-009 ad_valid  in  1  sample strobe; ad_data is valid in this cycle.
REQ-010 m_axis_tdata  out  32  [15:0] real part, [31:16] imaginary part (always 0).
REQ-011 m_axis_tvalid  out  1  AXI-Stream valid.
REQ-012 m_axis_tready  in  1  AXI-Stream ready from the FFT core.
REQ-013 m_axis_tlast  out  1  marks the FRAME_LEN-th beat of a frame.
REQ-014 busy  out  1  high from start acceptance until the last beat is handshaken.
REQ-015 frame_done  out  1  one-cycle pulse after the last beat.
REQ-016 overflow  out  1  sticky flag: at least one sample was dropped in this frame.

Function
REQ-017 States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: start -> CAPTURE; FIFO, in_cnt, out_cnt and overflow are cleared.
- CAPTURE -> DRAIN when in_cnt reaches FRAME_LEN.
- DRAIN -> DONE on the handshake of the tlast beat.
- DONE -> IDLE after 1 cycle.
REQ-018 start is ignored outside IDLE.
REQ-019 In CAPTURE, ad_valid with the FIFO not full writes the converted sample and increments in_cnt; no samples are accepted in any other state.
REQ-020 Real-part conversion:
- Sign-extend the DATA_W code to 16 bits when OFFSET_BIN=1, after inverting its MSB.
- Zero-extend the code when OFFSET_BIN=0.
REQ-021 If ad_valid arrives in CAPTURE while the FIFO is full and no read occurs in that cycle:
- the sample is dropped;
- in_cnt is not incremented;
- overflow is set and stays set until the next accepted start.
REQ-022 When the FIFO is full, a read and a write in the same cycle are both performed, with no drop.
REQ-023 A beat transfers when m_axis_tvalid and m_axis_tready are both high; out_cnt then increments.
REQ-024 m_axis_tvalid is high whenever the FIFO holds data in CAPTURE or DRAIN.
REQ-025 tvalid, tdata and tlast hold stable while tvalid=1 and tready=0.
REQ-026 tvalid does not drop until a handshake occurs.
REQ-027 m_axis_tlast is high only on the beat where out_cnt = FRAME_LEN-1.
REQ-028 The first sample is presented on m_axis at least 1 cycle and at most 2 cycles after it is written, when the FIFO was empty.
REQ-029 With tready held high and the FIFO non-empty, one beat is sent per cycle.
REQ-030 busy is high in CAPTURE and DRAIN; frame_done is high only in DONE.
REQ-031 Counter widths are log2(FRAME_LEN)+1 bits; no wrap-around occurs within a frame.

Reset
REQ-032 rst_n low, at any time including mid-frame, immediately forces the following, with no partial frame resumed:
- state IDLE;
- FIFO empty;
- in_cnt = 0, out_cnt = 0;
- m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0;
- busy = 0, frame_done = 0, overflow = 0.
REQ-033 After rst_n deasserts, the block waits in IDLE for a start pulse.

Verification
REQ-034 FRAME_LEN=16, tready=1, ad_valid every cycle, codes 0..15, OFFSET_BIN=1 -> 16 beats with tdata[15:0] = 0xF800..0xF80F, tlast only on the 16th beat, frame_done one cycle later, overflow=0.
REQ-035 Apply tready=0 for 20 cycles mid-frame while ad_valid=1 every cycle with FIFO_DEPTH=16 -> tdata and tvalid hold stable, overflow=1, the frame still ends after exactly FRAME_LEN beats with tlast.
REQ-036 ad_valid every 4th cycle, tready toggling 1/0 -> all FRAME_LEN samples arrive in order with no loss and overflow=0.
REQ-037 Pulse start while busy -> no effect; a start after frame_done captures a new frame and clears overflow.
REQ-038 Pulse rst_n low at beat 7 of 16 -> all outputs go to 0 that cycle; a new start yields a complete 16-beat frame.
REQ-039 OFFSET_BIN=0, code 0xFFF -> tdata = 0x00000FFF.
